// File: rtl/sha256_round_engine.sv
`timescale 1ns/1ps
// SHA-256 compression: 64 rounds over a streamed message schedule, then a feed-forward add of the IV.
// Latency: 65 clk from the accepted start to the done pulse, plus one clk per stalled round.
// Backpressure: w_ready is high for the whole ROUND phase; w_valid low stalls the round and holds round/a..h.
//
// Ports:
//   clk, n_rst (sync, active-low)          clock and reset
//   start, use_default, chain_in[255:0]    block launch; IV select (standard IV or chain_in, H0 in MSBs)
//   w_data[31:0], w_valid, w_ready         schedule word W[round] handshake
//   round[5:0]                             index of the requested word (0 outside ROUND)
//   busy, done, hash_out[255:0]            status, one-cycle completion pulse, held result
module sha256_round_engine (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         use_default,
  input  logic [255:0] chain_in,
  input  logic [31:0]  w_data,
  input  logic         w_valid,
  output logic         w_ready,
  output logic [5:0]   round,
  output logic         busy,
  output logic         done,
  output logic [255:0] hash_out
);

  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  // Field order puts a in the MSBs so the struct lines up with the H0..H7 packing.
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } work_t;

  localparam logic [255:0] STD_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  state_t       state, state_nxt;
  work_t        wk, wk_rnd;
  logic [255:0] wk_flat;
  logic [255:0] iv_reg, iv_sel, hash_sum;
  logic [31:0]  sig0, sig1, ch, maj, t1, t2;
  logic         load, step, finish;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    w_ready   = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        busy    = 1'b1;
        w_ready = 1'b1;
        step    = w_valid;
        if (w_valid && (round == 6'd63)) state_nxt = FINAL;
      end
      FINAL: begin
        busy      = 1'b1;
        finish    = 1'b1;
        state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- round function ----------------
  assign iv_sel  = use_default ? STD_IV : chain_in;
  assign wk_flat = wk;

  always_comb begin
    sig0 = rotr(wk.a, 2) ^ rotr(wk.a, 13) ^ rotr(wk.a, 22);
    sig1 = rotr(wk.e, 6) ^ rotr(wk.e, 11) ^ rotr(wk.e, 25);
    ch   = (wk.e & wk.f) ^ (~wk.e & wk.g);
    maj  = (wk.a & wk.b) ^ (wk.a & wk.c) ^ (wk.b & wk.c);
    t1   = wk.h + sig1 + ch + K[round] + w_data;
    t2   = sig0 + maj;

    wk_rnd   = wk;
    wk_rnd.a = t1 + t2;
    wk_rnd.b = wk.a;
    wk_rnd.c = wk.b;
    wk_rnd.d = wk.c;
    wk_rnd.e = wk.d + t1;
    wk_rnd.f = wk.e;
    wk_rnd.g = wk.f;
    wk_rnd.h = wk.g;
  end

  // Feed-forward: each 32-bit lane added independently, carries do not cross lanes.
  always_comb begin
    hash_sum = '0;
    for (int i = 0; i < 8; i++) begin
      hash_sum[i*32 +: 32] = iv_reg[i*32 +: 32] + wk_flat[i*32 +: 32];
    end
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wk       <= '0;
      iv_reg   <= '0;
      hash_out <= '0;
      round    <= '0;
      done     <= 1'b0;
    end else begin
      done <= finish;
      if (load) begin
        iv_reg <= iv_sel;
        wk     <= work_t'(iv_sel);
        round  <= '0;
      end else if (step) begin
        wk    <= wk_rnd;
        // Wraps 63 -> 0 on the last round, so round reads 0 in FINAL/DONE.
        round <= round + 6'd1;
      end
      if (finish) hash_out <= hash_sum;
    end
  end

endmodule

// File: tb/tb_sha256_round_engine.sv
`timescale 1ns/1ps
module tb_sha256_round_engine;

  logic         clk = 1'b0;
  logic         n_rst;
  logic         start;
  logic         use_default;
  logic [255:0] chain_in;
  logic [31:0]  w_data;
  logic         w_valid;
  logic         w_ready;
  logic [5:0]   round;
  logic         busy;
  logic         done;
  logic [255:0] hash_out;

  int checks = 0;
  int errors = 0;

  logic [31:0]  sched [64];
  logic [255:0] last_hash;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] H_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] H_EMPTY =
    256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
  localparam logic [255:0] H_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  sha256_round_engine dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .use_default (use_default),
    .chain_in    (chain_in),
    .w_data      (w_data),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .round       (round),
    .busy        (busy),
    .done        (done),
    .hash_out    (hash_out)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Fill sched[0..15] from a 512-bit block (W0 in the MSBs) and expand to 64 words.
  task automatic load_block(input logic [511:0] blk);
    for (int i = 0; i < 16; i++) sched[i] = blk[511 - 32*i -: 32];
    for (int t = 16; t < 64; t++) begin
      sched[t] = (ror(sched[t-2], 17) ^ ror(sched[t-2], 19) ^ (sched[t-2] >> 10))
               + sched[t-7]
               + (ror(sched[t-15], 7) ^ ror(sched[t-15], 18) ^ (sched[t-15] >> 3))
               + sched[t-16];
    end
  endtask

  // Compression of sched[] on top of iv, using an array of eight working words.
  function automatic logic [255:0] ref_hash(input logic [255:0] iv);
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) v[i] = iv[255 - 32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + sched[t];
      t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = iv[255 - 32*i -: 32] + v[i];
    return r;
  endfunction

  // ---------------- block driver ----------------
  // Starts a block, streams sched[] with 'stalls' idle cycles mixed in, pulses start
  // again when 'poke' words have been consumed, and checks every cycle until done.
  task automatic run_block(input logic ud, input logic [255:0] cin, input int stalls,
                           input int poke, input logic [255:0] exp, input string name);
    int   consumed;
    int   left;
    int   cyc;
    logic in_round;
    consumed = 0;
    left     = stalls;
    cyc      = 0;
    start       = 1'b1;
    use_default = ud;
    chain_in    = cin;
    w_valid     = 1'b1;
    w_data      = $urandom;
    @(posedge clk); #1;
    start    = 1'b0;
    chain_in = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    while (consumed <= 64) begin
      in_round = (consumed < 64);
      checks++;
      if (done !== 1'b0 || busy !== 1'b1 || w_ready !== in_round ||
          round !== (in_round ? consumed[5:0] : 6'd0) || hash_out !== last_hash) begin
        errors++;
        $display("FAIL %s cycle %0d: done=%b busy=%b w_ready=%b round=%0d hash=%h, want done=0 busy=1 w_ready=%b round=%0d hash=%h",
                 name, cyc, done, busy, w_ready, round, hash_out, in_round,
                 in_round ? consumed : 0, last_hash);
      end
      if (in_round) begin
        if (consumed == poke) begin
          start       = 1'b1;
          use_default = 1'b0;
          chain_in    = '0;
        end
        if (left > 0 && ($urandom_range(0, 2) == 0 || consumed >= 60)) begin
          w_valid = 1'b0;
          w_data  = $urandom;
          left    = left - 1;
        end else begin
          w_valid = 1'b1;
          w_data  = sched[consumed];
        end
      end else begin
        w_valid = 1'($urandom_range(0, 1));
        w_data  = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
      start = 1'b0;
      if (!in_round || w_valid) consumed++;
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || w_ready !== 1'b0 || round !== 6'd0) begin
      errors++;
      $display("FAIL %s done_pulse after %0d cycles: done=%b busy=%b w_ready=%b round=%0d, want 1 0 0 0",
               name, cyc, done, busy, w_ready, round);
    end
    checks++;
    if (hash_out !== exp) begin
      errors++;
      $display("FAIL %s hash: got %h want %h", name, hash_out, exp);
    end
    last_hash = exp;
    w_valid = 1'b0;
  endtask

  // One cycle after done: pulse has dropped, engine idle, result held.
  task automatic idle_check(input string name);
    w_valid = 1'b1;
    w_data  = $urandom;
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || w_ready !== 1'b0 || round !== 6'd0 || hash_out !== last_hash) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b w_ready=%b round=%0d hash=%h, want 0 0 0 0 %h",
               name, done, busy, w_ready, round, hash_out, last_hash);
    end
    w_valid = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_rst = 1'b0;
    start = 1'b1;
    w_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || w_ready !== 1'b0 || round !== 6'd0 || hash_out !== '0) begin
      errors++;
      $display("FAIL reset: done=%b busy=%b w_ready=%b round=%0d hash=%h, want all zero",
               done, busy, w_ready, round, hash_out);
    end
    start   = 1'b0;
    w_valid = 1'b0;
    n_rst   = 1'b1;
    last_hash = '0;
    idle_check("reset_idle");
  endtask

  task automatic test_abc();
    load_block({32'h61626380, {14{32'h0}}, 32'h00000018});
    run_block(1'b1, {8{32'hdeadbeef}}, 0, -1, H_ABC, "abc");
    idle_check("abc");
  endtask

  task automatic test_empty();
    load_block({32'h80000000, {15{32'h0}}});
    run_block(1'b1, '0, 0, -1, H_EMPTY, "empty");
    idle_check("empty");
  endtask

  task automatic test_stalls();
    load_block({32'h61626380, {14{32'h0}}, 32'h00000018});
    run_block(1'b1, '0, 17, -1, H_ABC, "abc_stall");
    idle_check("abc_stall");
  endtask

  // Block 2 starts in the same cycle block 1's done is high.
  task automatic test_back_to_back_chain();
    logic [255:0] h1;
    load_block({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000});
    h1 = ref_hash(IV);
    run_block(1'b1, '0, 3, -1, h1, "chain_blk1");
    load_block({{15{32'h0}}, 32'h000001c0});
    run_block(1'b0, h1, 0, -1, H_TWO, "chain_blk2");
    idle_check("chain");
  endtask

  task automatic test_start_busy();
    load_block({32'h61626380, {14{32'h0}}, 32'h00000018});
    run_block(1'b1, '0, 0, 10, H_ABC, "start_busy");
    idle_check("start_busy");
  endtask

  task automatic test_abort();
    int seen_done;
    int bad;
    load_block({32'h61626380, {14{32'h0}}, 32'h00000018});
    start = 1'b1;
    use_default = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    w_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      w_data = sched[k];
      @(posedge clk); #1;
    end
    checks++;
    if (round !== 6'd30 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: round=%0d busy=%b, want 30 1", round, busy);
    end
    n_rst = 1'b0;
    @(posedge clk); #1;
    n_rst = 1'b1;
    last_hash = '0;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || w_ready !== 1'b0 || round !== 6'd0 || hash_out !== '0) begin
      errors++;
      $display("FAIL abort_reset: done=%b busy=%b w_ready=%b round=%0d hash=%h, want all zero",
               done, busy, w_ready, round, hash_out);
    end
    // Valid words in IDLE must not wake the engine or produce a done.
    seen_done = 0;
    bad = 0;
    for (int k = 0; k < 70; k++) begin
      w_valid = 1'b1;
      w_data  = $urandom;
      @(posedge clk); #1;
      if (done !== 1'b0) seen_done++;
      if (busy !== 1'b0 || hash_out !== '0) bad++;
    end
    checks++;
    if (seen_done != 0 || bad != 0) begin
      errors++;
      $display("FAIL abort_quiet: done cycles=%0d busy/hash cycles=%0d, want 0 0", seen_done, bad);
    end
    w_valid = 1'b0;
    test_abc();
  endtask

  task automatic test_random();
    logic         ud;
    logic [255:0] cin;
    logic [255:0] exp;
    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 64; i++) sched[i] = $urandom;
      ud  = 1'($urandom_range(0, 1));
      cin = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      exp = ref_hash(ud ? IV : cin);
      run_block(ud, cin, $urandom_range(0, 8), -1, exp, "random");
      if (n[0]) idle_check("random");
    end
  endtask

  initial begin
    n_rst       = 1'b0;
    start       = 1'b0;
    use_default = 1'b0;
    chain_in    = '0;
    w_data      = '0;
    w_valid     = 1'b0;
    last_hash   = '0;
    test_reset();
    test_abc();
    test_empty();
    test_stalls();
    test_back_to_back_chain();
    test_start_busy();
    test_abort();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sha256_round_engine.md
# sha256_round_engine

Consumes the 64-word SHA-256 message schedule, one word per round, and runs the 64 compression rounds to produce a 256-bit chaining hash. It sits downstream of the schedule-expansion block. It drives the round index that the expander uses to select W[t], and it accepts W[t] over a valid/ready handshake. Its output either feeds the next block's chaining input or goes to the miner's difficulty comparator.

## Interface
- No parameters. The K[0..63] constants are a fixed internal ROM holding the standard FIPS 180-4 values.
- clk  in  1  system clock; all state updates on the rising edge
- n_rst  in  1  reset, synchronous, active-low
- start  in  1  begin a new block; honoured only in IDLE or DONE
- use_default  in  1  sampled with start: 1 = use the standard IV (6a09e667 … 5be0cd19); 0 = use chain_in
- chain_in  in  256  initial H0..H7, with H0 in [255:224] and H7 in [31:0]
- w_data  in  32  schedule word W[round]
- w_valid  in  1  w_data is valid
- w_ready  out  1  engine will consume w_data this cycle; equals (state == ROUND)
- round  out  6  index t of the word currently requested; 0 outside ROUND
- busy  out  1  high in ROUND and FINAL
- done  out  1  one-cycle pulse when hash_out updates
- hash_out  out  256  final H0..H7, same packing as chain_in; held until the next done

## Operation
- States: IDLE, ROUND, FINAL, DONE.
- IDLE/DONE → ROUND on start:
  - Latch the IV (from use_default or chain_in) into iv_reg.
  - Load a..h ← IV.
  - round ← 0.
- ROUND:
  - On a clock edge where w_valid & w_ready, perform one round with t = round:
    - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + w_data
    - T2 = Σ0(a) + Maj(a,b,c)
    - h←g, g←f, f←e, e←d+T1, d←c, c←b, b←a, a←T1+T2
    - round ← round+1
  - When w_valid is 0, the working registers and round hold (stall).
  - After the round with t = 63, go to FINAL. round wraps to 0.
- FINAL: hash_out ← iv_reg + {a..h}, added per 32-bit word. Assert done. Go to DONE.
- DONE: hash_out is held. start restarts the engine; otherwise it stays in DONE.
- Function definitions:
  - Σ0 = ROTR2 ^ ROTR13 ^ ROTR22
  - Σ1 = ROTR6 ^ ROTR11 ^ ROTR25
  - Ch = (e&f) ^ (~e&g)
  - Maj = (a&b) ^ (a&c) ^ (b&c)
- All additions are modulo 2^32. Carries are discarded.
- start while busy is ignored: no restart and no IV relatch.
- w_data presented outside ROUND is ignored.

## Timing
- Reset (n_rst low at an edge) applies to everything: state=IDLE; a..h, iv_reg, hash_out, round = 0; done, busy, w_ready = 0.
- Reset mid-ROUND or mid-FINAL aborts the block. No done pulse is produced, and hash_out returns to 0.
- Start edge E0 (start=1 sampled): ROUND begins, and busy and w_ready go high in the cycle following E0.
- With w_valid held high, rounds 0..63 occur at edges E1..E64, and FINAL is occupied in the cycle after E64.
- At E65, hash_out updates and done=1 for exactly the cycle after E65; busy falls at the same time.
- Start-to-done latency is 65 clocks plus the number of stall cycles (cycles in ROUND with w_valid=0).
- round changes only on a consuming edge, so the expander may compute W[round] combinationally from round.
- start sampled in DONE in the same cycle done is high is accepted: the next block starts and hash_out keeps its value until that block's done.

## Test plan
- "abc" single block with use_default=1:
  - W0=61626380, W1..W14=0, W15=00000018, W16..63 from a reference model; w_valid held high.
  - Required: hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, with done exactly 65 clocks after the start edge.
- Empty message:
  - W0=80000000, W1..W15=0, W16..63 from the model.
  - Required: hash_out = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Stalls:
  - Rerun "abc" with w_valid low for 17 pseudo-random cycles.
  - Required: identical hash; done at 82 clocks; round and a..h frozen during each stall.
- Chaining:
  - Block 1 of the 56-byte message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (use_default=1).
  - Then block 2 (padding) with use_default=0 and chain_in = prior hash_out.
  - Required: hash_out = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Abort:
  - Drop n_rst for 1 cycle at round 30.
  - Required: state returns to IDLE; hash_out=0; no done pulse. A fresh "abc" run after reset then produces the correct hash.
- start while busy:
  - Pulse start at round 10 with use_default=0 and chain_in=0.
  - Required: ignored; the "abc" result is unchanged.
